calc_datapath: RTL and testbench

Operand capture and arithmetic engine for the switch-driven calculator, directly downstream of the entry-sequencing state machine. It consumes that machine's 3-bit state code, latches the switch operand during the two entry phases, and runs a multi-cycle add, subtract, shift-add multiply or restoring divide once the calculate phase is reached. It presents result and status to the display stage.

---
 rtl/calc_datapath_if.sv | 26 ++
 rtl/calc_datapath.sv | 199 +++++++++++++++++++
 tb/tb_calc_datapath.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/calc_datapath_if.sv
// Calculator datapath bus: sequencer state and switch operand in, captured
// operands, result and status out.
interface calc_datapath_if #(
  parameter int WIDTH = 8
);
  logic [2:0]         state;
  logic [WIDTH-1:0]   sw_operand;
  logic [1:0]         op_sel;
  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op2;
  logic [2*WIDTH-1:0] result;
  logic               busy;
  logic               done;
  logic               neg;
  logic               err_div0;

  modport master (
    output state, sw_operand, op_sel,
    input  op1, op2, result, busy, done, neg, err_div0
  );

  modport slave (
    input  state, sw_operand, op_sel,
    output op1, op2, result, busy, done, neg, err_div0
  );
endinterface

// File: rtl/calc_datapath.sv
// Operand capture and multi-cycle add/sub/shift-add multiply/restoring divide
// engine driven by the entry sequencer's state code.
module calc_datapath #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  calc_datapath_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'b000,
    SEQ_OP1    = 3'b001,
    SEQ_OP1_WR = 3'b010,
    SEQ_OP2    = 3'b011,
    SEQ_OP2_WR = 3'b100,
    SEQ_CALC   = 3'b101
  } seq_e;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;
  typedef enum logic [1:0] {ENG_IDLE, ENG_RUN, ENG_DONE} eng_e;

  eng_e               fsm_q, fsm_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d, done_q, done_d, neg_q, neg_d, err_q, err_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   aux_q, aux_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // acc holds the product (mul) or the partial remainder in its low bits (div);
  // aux holds the multiplier (mul) or the dividend shifting into the quotient (div).
  logic [WIDTH:0]     sum_w, diff_w;
  logic [2*WIDTH-1:0] mul_acc_nx;
  logic [WIDTH:0]     div_shift, div_trial, rem_nx;
  logic               div_ge;
  logic [WIDTH-1:0]   quo_nx;

  assign sum_w      = {1'b0, op1_q} + {1'b0, op2_q};
  assign diff_w     = {1'b0, op1_q} - {1'b0, op2_q};
  assign mul_acc_nx = aux_q[0] ? acc_q + mcand_q : acc_q;
  assign div_shift  = {acc_q[WIDTH-1:0], aux_q[WIDTH-1]};
  assign div_trial  = div_shift - {1'b0, op2_q};
  assign div_ge     = div_shift >= {1'b0, op2_q};
  assign rem_nx     = div_ge ? div_trial : div_shift;
  assign quo_nx     = {aux_q[WIDTH-2:0], div_ge};

  always_comb begin
    fsm_d    = fsm_q;
    op_d     = op_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    neg_d    = neg_q;
    err_d    = err_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    aux_d    = aux_q;
    cnt_d    = cnt_q;

    if (bus.state == SEQ_OP1) op1_d = bus.sw_operand;
    if (bus.state == SEQ_OP2) op2_d = bus.sw_operand;

    unique case (fsm_q)
      ENG_IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (bus.state == SEQ_CALC) begin
          fsm_d   = ENG_RUN;
          op_d    = op_e'(bus.op_sel);
          acc_d   = '0;
          mcand_d = {{WIDTH{1'b0}}, op1_q};
          aux_d   = (bus.op_sel == 2'b10) ? op2_q : op1_q;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          neg_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      ENG_RUN: begin
        if (bus.state != SEQ_CALC) begin
          fsm_d  = ENG_IDLE;
          busy_d = 1'b0;
          done_d = 1'b0;
        end else begin
          unique case (op_q)
            OP_ADD: begin
              result_d = {{(WIDTH-1){1'b0}}, sum_w};
              fsm_d    = ENG_DONE;
            end
            OP_SUB: begin
              result_d = {{(WIDTH-1){diff_w[WIDTH]}}, diff_w};
              neg_d    = diff_w[WIDTH];
              fsm_d    = ENG_DONE;
            end
            OP_MUL: begin
              acc_d   = mul_acc_nx;
              mcand_d = mcand_q << 1;
              aux_d   = aux_q >> 1;
              cnt_d   = cnt_q - 1'b1;
              if (cnt_q == CW'(1)) begin
                result_d = mul_acc_nx;
                fsm_d    = ENG_DONE;
              end
            end
            OP_DIV: begin
              if (op2_q == '0) begin
                result_d = '0;
                err_d    = 1'b1;
                fsm_d    = ENG_DONE;
              end else begin
                acc_d = {{(WIDTH-1){1'b0}}, rem_nx};
                aux_d = quo_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                  result_d = {rem_nx[WIDTH-1:0], quo_nx};
                  fsm_d    = ENG_DONE;
                end
              end
            end
            default: fsm_d = ENG_DONE;
          endcase
          if (fsm_d == ENG_DONE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      ENG_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (bus.state != SEQ_CALC) begin
          fsm_d  = ENG_IDLE;
          done_d = 1'b0;
        end
      end
      default: begin
        fsm_d  = ENG_IDLE;
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase

    if (bus.state == SEQ_IDLE) begin
      fsm_d    = ENG_IDLE;
      op1_d    = '0;
      op2_d    = '0;
      result_d = '0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      neg_d    = 1'b0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q    <= ENG_IDLE;
      op_q     <= OP_ADD;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      aux_q    <= '0;
      cnt_q    <= '0;
    end else begin
      fsm_q    <= fsm_d;
      op_q     <= op_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      aux_q    <= aux_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.op1      = op1_q;
  assign bus.op2      = op2_q;
  assign bus.result   = result_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.neg      = neg_q;
  assign bus.err_div0 = err_q;
endmodule

// File: tb/tb_calc_datapath.sv
// Directed checks of calc_datapath: capture, add/sub/mul/div timing and
// results, divide-by-zero, asynchronous reset mid-multiply, exits from DONE.
module tb_calc_datapath;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  calc_datapath_if #(.WIDTH(WIDTH)) bus ();

  calc_datapath #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.state = 3'b000; tick();
    bus.state = 3'b001; bus.sw_operand = a; tick();
    bus.state = 3'b010; bus.sw_operand = 8'd7; tick();
    bus.state = 3'b011; bus.sw_operand = b; tick();
    bus.state = 3'b100; bus.sw_operand = 8'd7; tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_op1"}, 64'(bus.op1), 64'd0);
    check({tag, "_op2"}, 64'(bus.op2), 64'd0);
    check({tag, "_result"}, 64'(bus.result), 64'd0);
    check({tag, "_flags"}, 64'({bus.busy, bus.done, bus.neg, bus.err_div0}), 64'd0);
  endtask

  // Runs a WIDTH-cycle operation from T0, toggling op_sel during RUN, and
  // checks busy/done on every cycle up to T0+WIDTH+1.
  task automatic run_long(input string tag, input logic [1:0] op, input logic [15:0] exp);
    bus.op_sel = op;
    bus.state  = 3'b101;
    for (int unsigned k = 1; k <= WIDTH; k++) begin
      tick();
      check({tag, "_busy"}, 64'(bus.busy), 64'd1);
      check({tag, "_done_early"}, 64'(bus.done), 64'd0);
      bus.op_sel = k[0] ? ~op : op;
    end
    tick();
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    check({tag, "_result"}, 64'(bus.result), 64'(exp));
    tick();
    check({tag, "_hold_done"}, 64'(bus.done), 64'd1);
    check({tag, "_hold_result"}, 64'(bus.result), 64'(exp));
  endtask

  initial begin
    bus.state = 3'b000;
    bus.sw_operand = '0;
    bus.op_sel = 2'b00;
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // add with a switch change during op1-written that must not be captured
    enter(8'd200, 8'd100);
    check("add_op1", 64'(bus.op1), 64'd200);
    check("add_op2", 64'(bus.op2), 64'd100);
    bus.op_sel = 2'b00; bus.state = 3'b101;
    check("add_t0_busy", 64'(bus.busy), 64'd0);
    tick();
    check("add_t1_busy", 64'(bus.busy), 64'd1);
    check("add_t1_done", 64'(bus.done), 64'd0);
    tick();
    check("add_t2_done", 64'(bus.done), 64'd1);
    check("add_t2_busy", 64'(bus.busy), 64'd0);
    check("add_result", 64'(bus.result), 64'h012C);

    // subtract with negative result
    enter(8'd5, 8'd9);
    bus.op_sel = 2'b01; bus.state = 3'b101;
    tick();
    check("sub_t1_done", 64'(bus.done), 64'd0);
    tick();
    check("sub_done", 64'(bus.done), 64'd1);
    check("sub_result", 64'(bus.result), 64'hFFFC);
    check("sub_neg", 64'(bus.neg), 64'd1);

    enter(8'd255, 8'd255);
    check("mul_neg_cleared", 64'(bus.neg), 64'd0);
    run_long("mul", 2'b10, 16'hFE01);

    enter(8'd100, 8'd7);
    run_long("div", 2'b11, 16'h020E);

    // divide by zero
    enter(8'd3, 8'd0);
    bus.op_sel = 2'b11; bus.state = 3'b101;
    tick();
    check("div0_t1_busy", 64'(bus.busy), 64'd1);
    tick();
    check("div0_done", 64'(bus.done), 64'd1);
    check("div0_err", 64'(bus.err_div0), 64'd1);
    check("div0_result", 64'(bus.result), 64'd0);

    // leave DONE without passing idle: err must clear on the next start
    bus.state = 3'b011; bus.sw_operand = 8'd5; tick();
    check("exit_done", 64'(bus.done), 64'd0);
    check("exit_err_kept", 64'(bus.err_div0), 64'd1);
    bus.op_sel = 2'b00; bus.state = 3'b101;
    tick();
    check("restart_err_clr", 64'(bus.err_div0), 64'd0);
    tick();
    check("restart_add", 64'(bus.result), 64'h0008);

    // asynchronous reset at T0+4 of a multiply
    enter(8'd255, 8'd255);
    bus.op_sel = 2'b10; bus.state = 3'b101;
    tick(); tick(); tick(); tick();
    check("rst_pre_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    bus.state = 3'b000;
    tick();
    reset = 1'b0;
    tick(); tick();
    check("post_rst_done", 64'(bus.done), 64'd0);
    enter(8'd12, 8'd11);
    run_long("mul2", 2'b10, 16'h0084);

    // DONE -> 000 clears everything on the next edge
    bus.state = 3'b000; tick();
    check_all_zero("done_to_idle");

    // DONE -> 001 drops done but keeps the result
    enter(8'd3, 8'd4);
    bus.op_sel = 2'b00; bus.state = 3'b101;
    tick(); tick();
    check("add34", 64'(bus.result), 64'h0007);
    bus.state = 3'b001; bus.sw_operand = 8'd9; tick();
    check("to001_done", 64'(bus.done), 64'd0);
    check("to001_busy", 64'(bus.busy), 64'd0);
    check("to001_result", 64'(bus.result), 64'h0007);
    check("to001_op1", 64'(bus.op1), 64'd9);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
